// File: rtl/vga_sdram_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sdram_reader_if
//  Description : Signal bundle between the VGA display reader, the SDRAM
//                controller read FIFO and the VGA DAC. The master modport is
//                the reader itself; the slave modport is the surrounding
//                environment (control inputs, FIFO data and the DAC side).
//
//  Signals:
//    en          display enable
//    tp_sel      test-pattern select (only used with VGA_TEST_PATTERN_EN)
//    rd1_data    read-FIFO output word, valid one cycle after rd1
//    rd1         read-FIFO pop request
//    rd1_load    read address rewind / read-FIFO clear
//    vga_r/g/b   RGB565 pixel components
//    vga_hs      horizontal sync, active low
//    vga_vs      vertical sync, active low
//    vga_blank_n high during active video
//    frame_start one-cycle pulse on the first active pixel of each frame
//
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_sdram_reader_if;
  logic        en;
  logic        tp_sel;
  logic [15:0] rd1_data;
  logic        rd1;
  logic        rd1_load;
  logic [4:0]  vga_r;
  logic [5:0]  vga_g;
  logic [4:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_blank_n;
  logic        frame_start;

  modport master (
    input  en,
    input  tp_sel,
    input  rd1_data,
    output rd1,
    output rd1_load,
    output vga_r,
    output vga_g,
    output vga_b,
    output vga_hs,
    output vga_vs,
    output vga_blank_n,
    output frame_start
  );

  modport slave (
    output en,
    output tp_sel,
    output rd1_data,
    input  rd1,
    input  rd1_load,
    input  vga_r,
    input  vga_g,
    input  vga_b,
    input  vga_hs,
    input  vga_vs,
    input  vga_blank_n,
    input  frame_start
  );
endinterface
`default_nettype wire

// File: rtl/vga_sdram_reader.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sdram_reader
//  Description : Display-side consumer of the SDRAM controller read port.
//                Generates VGA timing (640x480@60 by default) on the pixel
//                clock, pops one RGB565 word per active pixel, and holds
//                rd1_load high for the whole first vsync line so every frame
//                restarts from the frame-buffer base.
//
//  Ports:
//    clk    pixel clock (same clock as the read-FIFO read side)
//    rst_n  asynchronous, active-low reset
//    bus    vga_sdram_reader_if.master (enable, FIFO port, DAC outputs)
//
//  Optional feature:
//    VGA_TEST_PATTERN_EN  when defined, tp_sel=1 replaces active RGB with
//                         eight vertical colour bars. Without it tp_sel is
//                         ignored and no logic is generated for it.
//
//  Revision    : 1.0  initial release
// ============================================================================
module vga_sdram_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vga_sdram_reader_if.master    bus
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  // Counter-width copies of the region boundaries keep every compare
  // width-matched.
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  // The load line is the first vsync line.
  localparam logic [VW-1:0] V_LOAD     = V_SYNC_BEG;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [HW-1:0] BAR_W      = HW'(H_ACTIVE / 8);
`endif

  // --------------------------------------------------------------------------
  // Timing counters
  // --------------------------------------------------------------------------
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;
  logic          rd1_load_r;

  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (!bus.en) begin
      // Parked at the start of the load line so that re-enabling leaves
      // the rest of vsync plus back porch for the FIFO to prefill.
      h_nxt = '0;
      v_nxt = V_LOAD;
    end else if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_nxt = h_cnt + 1'b1;
    end
  end

  // rd1_load is registered from the next-state line number, so it is high
  // exactly while v_cnt sits on the load line (and therefore also whenever
  // the display is disabled, because the counters are parked there).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt      <= '0;
      v_cnt      <= V_LOAD;
      rd1_load_r <= 1'b1;
    end else begin
      h_cnt      <= h_nxt;
      v_cnt      <= v_nxt;
      rd1_load_r <= (v_nxt == V_LOAD);
    end
  end

  // --------------------------------------------------------------------------
  // Region decode at the counter stage
  // --------------------------------------------------------------------------
  logic active;
  logic pop;
  logic hs_dec;
  logic vs_dec;
  logic fs_dec;

  always_comb begin
    active = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    pop    = bus.en && active;
    hs_dec = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
    vs_dec = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
    fs_dec = bus.en && (h_cnt == '0) && (v_cnt == '0);
  end

  assign bus.rd1      = pop;
  assign bus.rd1_load = rd1_load_r;

  // --------------------------------------------------------------------------
  // Two-stage output pipe. Stage 1 lines up the control decode with the
  // cycle in which the FIFO word appears; stage 2 registers the pixel.
  // Blanking follows the pop itself so that dropping en blanks exactly the
  // pixels that were never fetched.
  // --------------------------------------------------------------------------
  logic hs_s1, vs_s1, blank_s1, fs_s1;
  logic hs_s2, vs_s2, blank_s2, fs_s2;
  logic [15:0] pix;
  logic [15:0] rgb_s2;

`ifdef VGA_TEST_PATTERN_EN
  logic       tp_s1;
  logic [2:0] bar_s1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_s1    <= 1'b1;
      vs_s1    <= 1'b1;
      blank_s1 <= 1'b0;
      fs_s1    <= 1'b0;
    end else begin
      hs_s1    <= hs_dec;
      vs_s1    <= vs_dec;
      blank_s1 <= pop;
      fs_s1    <= fs_dec;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  // Bar index is only meaningful inside the active area, where it is 0..7.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp_s1  <= 1'b0;
      bar_s1 <= '0;
    end else begin
      tp_s1  <= bus.tp_sel;
      bar_s1 <= 3'(h_cnt / BAR_W);
    end
  end
`endif

  always_comb begin
    pix = blank_s1 ? bus.rd1_data : 16'h0000;
`ifdef VGA_TEST_PATTERN_EN
    if (blank_s1 && tp_s1) begin
      pix = {{5{bar_s1[2]}}, {6{bar_s1[1]}}, {5{bar_s1[0]}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_s2    <= 1'b1;
      vs_s2    <= 1'b1;
      blank_s2 <= 1'b0;
      fs_s2    <= 1'b0;
      rgb_s2   <= 16'h0000;
    end else begin
      hs_s2    <= hs_s1;
      vs_s2    <= vs_s1;
      blank_s2 <= blank_s1;
      fs_s2    <= fs_s1;
      rgb_s2   <= pix;
    end
  end

  assign bus.vga_r       = rgb_s2[15:11];
  assign bus.vga_g       = rgb_s2[10:5];
  assign bus.vga_b       = rgb_s2[4:0];
  assign bus.vga_hs      = hs_s2;
  assign bus.vga_vs      = vs_s2;
  assign bus.vga_blank_n = blank_s2;
  assign bus.frame_start = fs_s2;

endmodule
`default_nettype wire

// File: tb/tb_vga_sdram_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sdram_reader
//  Description : Self-checking bench for vga_sdram_reader using reduced
//                timing parameters. A position model derived from the
//                number of cycles since the frame origin predicts every
//                output; delayed outputs go through a scoreboard queue.
//
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_sdram_reader;

  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int HS  = 4;
  localparam int HBP = 3;
  localparam int VA  = 6;
  localparam int VFP = 1;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam int HT  = HA + HFP + HS + HBP;   // 25
  localparam int VT  = VA + VFP + VS + VBP;   // 11
  localparam int LOAD = VA + VFP;             // 7

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank;
    logic        fs;
    logic [15:0] rgb;
  } exp_t;

  localparam exp_t RST_EXP = '{hs: 1'b1, vs: 1'b1, blank: 1'b0, fs: 1'b0, rgb: 16'h0000};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vga_sdram_reader_if ifc();

  vga_sdram_reader #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Read FIFO model: non-show-ahead, contents are 0,1,2,... from the last
  // rewind.
  logic [15:0] fifo_word;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_word    <= 16'd0;
      ifc.rd1_data <= 16'd0;
    end else if (ifc.rd1_load) begin
      fifo_word <= 16'd0;
    end else if (ifc.rd1) begin
      ifc.rd1_data <= fifo_word;
      fifo_word    <= fifo_word + 16'd1;
    end
  end

  // Cycles since the frame origin (start of the load line).
  int pos;
  always @(posedge clk) begin
    if (!rst_n || !ifc.en) pos <= 0;
    else                   pos <= pos + 1;
  end

  exp_t sb[$];
  bit   chk_on = 1'b0;

  always @(negedge clk) begin
    int   h, v, b;
    logic act, erd;
    exp_t e, o;
    if (rst_n && chk_on) begin
      h   = pos % HT;
      v   = (LOAD + pos / HT) % VT;
      act = (h < HA) && (v < VA);
      erd = ifc.en && act;
      check_val("rd1", 32'(ifc.rd1), 32'(erd));
      check_val("rd1_load", 32'(ifc.rd1_load), 32'(v == LOAD));
      e.hs    = !((h >= HA + HFP) && (h < HA + HFP + HS));
      e.vs    = !((v >= VA + VFP) && (v < VA + VFP + VS));
      e.blank = erd;
      e.fs    = ifc.en && (h == 0) && (v == 0);
      e.rgb   = erd ? 16'(v * HA + h) : 16'h0000;
`ifdef VGA_TEST_PATTERN_EN
      if (erd && ifc.tp_sel) begin
        b = h / (HA / 8);
        e.rgb = {{5{b[2]}}, {6{b[1]}}, {5{b[0]}}};
      end
`endif
      sb.push_back(e);
      if (sb.size() > 2) begin
        o = sb.pop_front();
        check_val("rgb", 32'({ifc.vga_r, ifc.vga_g, ifc.vga_b}), 32'(o.rgb));
        check_val("hs", 32'(ifc.vga_hs), 32'(o.hs));
        check_val("vs", 32'(ifc.vga_vs), 32'(o.vs));
        check_val("blank_n", 32'(ifc.vga_blank_n), 32'(o.blank));
        check_val("frame_start", 32'(ifc.frame_start), 32'(o.fs));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rd1"}, 32'(ifc.rd1), 32'd0);
    check_val({tag, "_rd1_load"}, 32'(ifc.rd1_load), 32'd1);
    check_val({tag, "_hs"}, 32'(ifc.vga_hs), 32'd1);
    check_val({tag, "_vs"}, 32'(ifc.vga_vs), 32'd1);
    check_val({tag, "_blank_n"}, 32'(ifc.vga_blank_n), 32'd0);
    check_val({tag, "_rgb"}, 32'({ifc.vga_r, ifc.vga_g, ifc.vga_b}), 32'd0);
    check_val({tag, "_fs"}, 32'(ifc.frame_start), 32'd0);
  endtask

  task automatic prefill_sb();
    sb.delete();
    sb.push_back(RST_EXP);
    sb.push_back(RST_EXP);
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int   cnt;
    bit   hit;
    rst_n      = 1'b1;
    ifc.en     = 1'b1;
    ifc.tp_sel = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    prefill_sb();
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Two full frames with the display enabled.
    run_cycles(2 * HT * VT);

    // Drop enable at h=7 of line 3.
    hit = 1'b0;
    for (int i = 0; i < 2 * HT * VT && !hit; i++) begin
      if ((pos % HT) == 7 && ((LOAD + pos / HT) % VT) == 3) hit = 1'b1;
      else run_cycles(1);
    end
    check_val("en_drop_found", 32'(hit), 32'd1);
    ifc.en = 1'b0;
    #1 check_val("rd1_same_cycle", 32'(ifc.rd1), 32'd0);
    run_cycles(40);
    ifc.en = 1'b1;

    // First pop after re-enable comes after vsync remainder plus back porch.
    cnt = 0;
    @(negedge clk);
    while (!ifc.rd1 && cnt < 4 * HT * VT) begin
      @(negedge clk);
      cnt++;
    end
    check_val("first_rd1_delay", 32'(pos), 32'((VS + VBP) * HT));
    run_cycles(2 * HT * VT);

`ifdef VGA_TEST_PATTERN_EN
    ifc.tp_sel = 1'b1;
    run_cycles(HT * VT + 5);
    ifc.tp_sel = 1'b0;
    run_cycles(HT * VT);
`endif

    // Asynchronous reset in the middle of a frame.
    run_cycles(3 * HT + 9);
    rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    prefill_sb();
    run_cycles(2);
    rst_n = 1'b1;
    run_cycles(HT * VT + 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
